sync_filter_bank: RTL and testbench
===================================

Name: sync_filter_bank

Overview:
- Multi-channel input conditioner built around a configurable-depth flip-flop synchroniser.
- Each channel synchronises one asynchronous input into the clk domain with a per-channel reset value.
- Each channel then passes a consecutive-sample glitch filter and produces single-cycle rise and fall pulses on the filtered level.
- Sits at the chip-boundary edge of lab designs, ahead of receivers and FSMs that consume button, serial-line or handshake inputs.

Parameters:
- NUM_CH, 4: number of independent channels.
- STAGES, 2: synchroniser flop depth. Legal range 2..4.
- RST_VAL, {NUM_CH{1'b1}}: per-channel reset level for the synchroniser chain and the filtered output. Idle-high default.
- FILT_CNT, 3: consecutive stable samples required before filt_out follows sync_out. Legal range 1..15.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  reset; synchronous, active-low.
- filt_en  input  1  1 = glitch filter active; 0 = bypass (filt_out is sync_out registered once).
- async_in  input  NUM_CH  asynchronous inputs, one bit per channel.
- sync_out  output  NUM_CH  output of the last synchroniser stage.
- filt_out  output  NUM_CH  filtered level.
- rise_pulse  output  NUM_CH  one-cycle pulse on a filt_out 0->1 change.
- fall_pulse  output  NUM_CH  one-cycle pulse on a filt_out 1->0 change.

Behaviour:
- Reset
  - Sampled only on a posedge clk with n_rst==0.
  - All synchroniser stages and filt_out load RST_VAL. Counters load 0. rise_pulse and fall_pulse load 0.
  - Reset asserted mid-count aborts the count. No pulse is generated by reset or by release from reset.
  - Between reset assertion and the next edge, outputs hold their previous values.
- Synchroniser
  - Per channel, a shift chain of STAGES flops: stage0 <= async_in, stage[k] <= stage[k-1].
  - sync_out = stage[STAGES-1].
  - A change on async_in that is stable across an edge appears on sync_out STAGES edges later.
- Filter (filt_en==1), per channel, evaluated at each edge:
  - If sync_out == filt_out: cnt <= 0.
  - Else, if cnt == FILT_CNT-1: filt_out <= sync_out and cnt <= 0.
  - Else: cnt <= cnt+1.
  - filt_out therefore changes exactly FILT_CNT edges after sync_out changes, provided sync_out holds the new value for FILT_CNT consecutive sampled cycles.
  - Any reversion inside that window clears cnt. Glitches of 1..FILT_CNT-1 cycles are suppressed.
  - FILT_CNT==1 gives one edge of delay.
  - Counter width is CNT_W = $clog2(FILT_CNT)+1. The counter never wraps, because it saturates through the clear at FILT_CNT-1.
- Bypass (filt_en==0)
  - filt_out <= sync_out and cnt <= 0 every edge.
  - Toggling filt_en mid-count: on the edge where filt_en==0 the channel bypasses immediately. Re-enabling starts from cnt=0.
- Pulses
  - Registered on the same edge as the filt_out update.
  - rise_pulse[i] <= (next filt_out[i]==1 and current filt_out[i]==0). fall_pulse is the mirror.
  - Each pulse is high for exactly one cycle, coincident with the first cycle filt_out shows the new level. rise and fall are never high together on one channel.
- Channel independence
  - Channels share no state. Simultaneous events on several channels are all processed in the same cycle.
- End-to-end latency
  - async_in to filt_out/pulse: STAGES+FILT_CNT edges with filt_en=1; STAGES+1 edges with filt_en=0.

Decomposition:
- Package sync_pkg holds:
  - default constants SYNC_STAGES_DEF=2 and SYNC_FILT_CNT_DEF=3;
  - the function computing CNT_W;
  - a sync_edge_t packed struct {rise, fall}.
- Sub-module sync_filter_ch implements one channel: chain, counter, filt_out, pulses. Its parameters are STAGES, FILT_CNT and a 1-bit RST_BIT.
- sync_filter_bank instantiates NUM_CH copies via a generate loop, passing RST_VAL[i].

Test Plan:
- Reset then release with async_in=4'b1111 held, defaults -> sync_out=filt_out=4'b1111 throughout; no pulses ever.
- Channel 0 async_in 1->0 held -> sync_out[0] falls 2 edges later; filt_out[0] falls 5 edges after the input change; fall_pulse[0] high exactly 1 cycle, coincident with that change.
- Channel 1 low glitch of 2 cycles (FILT_CNT=3) -> sync_out[1] shows the glitch; filt_out[1] stays 1; no pulses. Repeat with a 3-cycle glitch -> filt_out[1] drops, fall_pulse[1] fires, then rise_pulse[1] fires 3 cycles after sync_out[1] returns high.
- filt_en=0, all channels toggled simultaneously -> filt_out follows sync_out 1 edge later; rise/fall pulses fire on all channels in the same cycle.
- Assert n_rst=0 for one edge while cnt=2 on channel 2 -> next cycle all state is RST_VAL and cnt=0; no pulse; the filter restarts its full FILT_CNT count after release.
- Sweep STAGES in {2,3,4} and FILT_CNT in {1,15} -> measured latency equals STAGES+FILT_CNT for every combination.

Source files
------------

// File: rtl/sync_filter_bank_pkg.sv
// sync_pkg: shared defaults, counter-width helper and edge-pulse struct for the filter bank
package sync_pkg;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int SYNC_FILT_CNT_DEF = 3;
  function automatic int cnt_w(input int filt_cnt);
    return $clog2(filt_cnt) + 1;
  endfunction
  typedef struct packed {
    logic rise;
    logic fall;
  } sync_edge_t;
endpackage

// File: rtl/sync_filter_bank_if.sv
// sync_filter_bank_if: bundles filt_en/async_in (to design) and sync_out/filt_out/rise_pulse/fall_pulse (from design)
interface sync_filter_bank_if #(parameter int NUM_CH = 4);
  logic filt_en;
  logic [NUM_CH-1:0] async_in, sync_out, filt_out, rise_pulse, fall_pulse;
  modport master(output filt_en, async_in, input sync_out, filt_out, rise_pulse, fall_pulse);
  modport slave(input filt_en, async_in, output sync_out, filt_out, rise_pulse, fall_pulse);
endinterface

// File: rtl/sync_filter_bank_ch.sv
// sync_filter_ch: one channel (clk, n_rst, filt_en_i, async_i -> sync_o, filt_o, edge_o) of synchroniser, glitch filter and edge pulses
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF,
  parameter int FILT_CNT = SYNC_FILT_CNT_DEF,
  parameter logic RST_BIT = 1'b1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       filt_en_i,
  input  logic       async_i,
  output logic       sync_o,
  output logic       filt_o,
  output sync_edge_t edge_o
);
  localparam int CNT_W = cnt_w(FILT_CNT);
  logic [STAGES-1:0] chain_q, chain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic filt_q, filt_d, differ, done;
  sync_edge_t edge_q, edge_d;
  assign sync_o = chain_q[STAGES-1];
  assign filt_o = filt_q;
  assign edge_o = edge_q;
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], async_i};
    differ = sync_o != filt_q;
    done = cnt_q == CNT_W'(FILT_CNT - 1);
    filt_d = (!filt_en_i || (differ && done)) ? sync_o : filt_q;
    cnt_d = (!filt_en_i || !differ || done) ? '0 : cnt_q + CNT_W'(1);
    edge_d.rise = filt_d & ~filt_q;
    edge_d.fall = ~filt_d & filt_q;
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      chain_q <= {STAGES{RST_BIT}};
      filt_q <= RST_BIT;
      cnt_q <= '0;
      edge_q <= '0;
    end else begin
      chain_q <= chain_d;
      filt_q <= filt_d;
      cnt_q <= cnt_d;
      edge_q <= edge_d;
    end
  end
endmodule

// File: rtl/sync_filter_bank.sv
// sync_filter_bank: NUM_CH independent conditioner channels (clk, n_rst, bus.slave) with per-channel reset level
module sync_filter_bank
  import sync_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int STAGES = SYNC_STAGES_DEF,
  parameter logic [NUM_CH-1:0] RST_VAL = {NUM_CH{1'b1}},
  parameter int FILT_CNT = SYNC_FILT_CNT_DEF
) (
  input logic clk,
  input logic n_rst,
  sync_filter_bank_if.slave bus
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sync_edge_t e;
    sync_filter_ch #(.STAGES(STAGES), .FILT_CNT(FILT_CNT), .RST_BIT(RST_VAL[i])) u_ch (
      .clk(clk),
      .n_rst(n_rst),
      .filt_en_i(bus.filt_en),
      .async_i(bus.async_in[i]),
      .sync_o(bus.sync_out[i]),
      .filt_o(bus.filt_out[i]),
      .edge_o(e)
    );
    assign bus.rise_pulse[i] = e.rise;
    assign bus.fall_pulse[i] = e.fall;
  end
endmodule

// File: tb/tb_sync_filter_bank.sv
// tb_sync_filter_bank: directed self-checking bench for sync_filter_bank
module tb_sync_filter_bank;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic sw_in = 1'b1;
  logic [5:0] sw_filt;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  sync_filter_bank_if #(.NUM_CH(4)) bus();
  sync_filter_bank dut (.clk(clk), .n_rst(n_rst), .bus(bus.slave));
  for (genvar g = 0; g < 6; g++) begin : g_sw
    sync_filter_bank_if #(.NUM_CH(1)) sb();
    sync_filter_bank #(.NUM_CH(1), .STAGES(2 + g / 2), .RST_VAL(1'b1), .FILT_CNT((g % 2) ? 15 : 1)) u_sw (
      .clk(clk), .n_rst(n_rst), .bus(sb.slave)
    );
    assign sb.async_in = sw_in;
    assign sb.filt_en = 1'b1;
    assign sw_filt[g] = sb.filt_out[0];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all(input string tag, input logic [3:0] s, input logic [3:0] f, input logic [3:0] r, input logic [3:0] fl);
    chk({tag, ".sync"}, 32'(bus.sync_out), 32'(s));
    chk({tag, ".filt"}, 32'(bus.filt_out), 32'(f));
    chk({tag, ".rise"}, 32'(bus.rise_pulse), 32'(r));
    chk({tag, ".fall"}, 32'(bus.fall_pulse), 32'(fl));
  endtask
  task automatic glitch(input int glen);
    bus.async_in = 4'b1101;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_all($sformatf("glitch%0d.k%0d", glen, k),
              (k >= 2 && k <= glen + 1) ? 4'b1101 : 4'hF,
              (glen >= 3 && k >= 5 && k < glen + 5) ? 4'b1101 : 4'hF,
              (glen >= 3 && k == glen + 5) ? 4'b0010 : 4'h0,
              (glen >= 3 && k == 5) ? 4'b0010 : 4'h0);
      if (k == glen) bus.async_in = 4'hF;
    end
  endtask
  initial begin
    int lat[6];
    int exp_lat[6] = '{3, 17, 4, 18, 5, 19};
    bus.async_in = 4'hF;
    bus.filt_en = 1'b1;
    tick();
    tick();
    chk_all("rst", 4'hF, 4'hF, 4'h0, 4'h0);
    n_rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_all($sformatf("idle.k%0d", k), 4'hF, 4'hF, 4'h0, 4'h0);
    end
    bus.async_in = 4'b1110;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_all($sformatf("ch0fall.k%0d", k), k >= 2 ? 4'b1110 : 4'hF, k >= 5 ? 4'b1110 : 4'hF,
              4'h0, k == 5 ? 4'b0001 : 4'h0);
    end
    bus.async_in = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_all($sformatf("ch0rise.k%0d", k), k >= 2 ? 4'hF : 4'b1110, k >= 5 ? 4'hF : 4'b1110,
              k == 5 ? 4'b0001 : 4'h0, 4'h0);
    end
    glitch(2);
    glitch(3);
    bus.filt_en = 1'b0;
    bus.async_in = 4'h0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_all($sformatf("byp0.k%0d", k), k >= 2 ? 4'h0 : 4'hF, k >= 3 ? 4'h0 : 4'hF,
              4'h0, k == 3 ? 4'hF : 4'h0);
    end
    bus.async_in = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_all($sformatf("byp1.k%0d", k), k >= 2 ? 4'hF : 4'h0, k >= 3 ? 4'hF : 4'h0,
              k == 3 ? 4'hF : 4'h0, 4'h0);
    end
    bus.filt_en = 1'b1;
    tick();
    bus.async_in = 4'b1011;
    for (int k = 1; k <= 4; k++) tick();
    n_rst = 1'b0;
    tick();
    chk_all("midrst", 4'hF, 4'hF, 4'h0, 4'h0);
    n_rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_all($sformatf("restart.k%0d", k), k >= 2 ? 4'b1011 : 4'hF, k >= 5 ? 4'b1011 : 4'hF,
              4'h0, k == 5 ? 4'b0100 : 4'h0);
    end
    bus.async_in = 4'hF;
    for (int k = 1; k <= 6; k++) tick();
    sw_in = 1'b0;
    for (int j = 0; j < 6; j++) lat[j] = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      for (int j = 0; j < 6; j++) if (lat[j] == 0 && sw_filt[j] == 1'b0) lat[j] = k;
    end
    for (int j = 0; j < 6; j++) chk($sformatf("sweep_lat%0d", j), 32'(lat[j]), 32'(exp_lat[j]));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
